// File: rtl/ysyx_22050550_wbu_pkg.sv
// Shared definitions for the ysyx_22050550 writeback stage: FSM encoding, CSR strobe
// indices, mstatus field positions and the default ecall mcause.
package ysyx_22050550_wbu_pkg;

    localparam logic [63:0] ECALL_MC_DEF = 64'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_TRAP2  = 2'd2
    } wb_state_t;

    // wbcsren bit positions
    localparam int CSR_MEPC    = 0;
    localparam int CSR_MCAUSE  = 1;
    localparam int CSR_MSTATUS = 3;

    // mstatus field positions
    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic [5:0]  csrwen;
        logic [63:0] csrdata;
    } entry_data_t;

    typedef struct packed {
        logic rwen;
        logic ecall;
        logic mret;
    } entry_ctrl_t;

    function automatic logic [63:0] trap_vector(input logic [63:0] mtvec);
        return mtvec & ~64'd3;
    endfunction

endpackage

// File: rtl/ysyx_22050550_wbu_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (MPIE<=MIE, MIE<=0, MPP<=M) and mret.
module ysyx_22050550_mstatus_upd
    import ysyx_22050550_wbu_pkg::*;
(
    input  logic [63:0] cur_mstatus,
    input  logic        is_trap,
    input  logic        is_mret,
    output logic [63:0] next_mstatus
);

    // Trap entry takes priority over mret
    always_comb begin
        next_mstatus = cur_mstatus;
        if (is_trap) begin
            next_mstatus[MS_MPIE]             = cur_mstatus[MS_MIE];
            next_mstatus[MS_MIE]              = 1'b0;
            next_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        end else if (is_mret) begin
            next_mstatus[MS_MIE]              = cur_mstatus[MS_MPIE];
            next_mstatus[MS_MPIE]             = 1'b1;
            next_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b00;
        end else begin
            next_mstatus = cur_mstatus;
        end
    end

endmodule

// File: rtl/ysyx_22050550_wbu_reg.sv
// Load-enabled register with asynchronous active-high clear; used to build the WBU entry.
module ysyx_22050550_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Capture din when enabled, clear on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_22050550_wbu.sv
// Writeback stage: single-deep entry, commit/trap sequencing, redirect to IFU.
// Optional retired-instruction counter enabled by YSYX_22050550_WB_INSTRET_EN.
module ysyx_22050550_wbu
    import ysyx_22050550_wbu_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0] ECALL_MC = ECALL_MC_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rdata,
    input  logic            in_rwen,
    input  logic [5:0]      in_csrwen,
    input  logic [XLEN-1:0] in_csrdata,
    input  logic            in_ecall,
    input  logic            in_mret,
    input  logic [XLEN-1:0] cur_mstatus,
    input  logic [XLEN-1:0] cur_mtvec,
    input  logic [XLEN-1:0] cur_mepc,
    output logic [4:0]      io_waddr,
    output logic [XLEN-1:0] io_wdata,
    output logic            io_wen,
    output logic            io_valid,
    output logic [XLEN-1:0] pc,
    output logic [7:0]      wbcsren,
    output logic [XLEN-1:0] wbmepc,
    output logic [XLEN-1:0] wbmcause,
    output logic [XLEN-1:0] wbmtvec,
    output logic [XLEN-1:0] wbmstatus,
    output logic [XLEN-1:0] wbmie,
    output logic [XLEN-1:0] wbmip,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef YSYX_22050550_WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    wb_state_t   state;
    entry_data_t ent_d;
    entry_ctrl_t ent_c;
    logic        accept;
    logic        mret_act;
    logic [63:0] ms_next;

    // Outputs decode only from registered state, so accept never depends on a same-cycle loop
    assign in_ready = (state == ST_IDLE) || ((state == ST_COMMIT) && !ent_c.ecall);
    assign accept   = in_valid && in_ready;
    assign mret_act = (state == ST_COMMIT) && ent_c.mret && !ent_c.ecall;

    ysyx_22050550_Reg #(.WIDTH($bits(entry_data_t))) u_ent_data (
        .clock (clock),
        .reset (reset),
        .wen   (accept),
        .din   ({in_pc, in_rd, in_rdata, in_csrwen, in_csrdata}),
        .dout  (ent_d)
    );

    ysyx_22050550_Reg #(.WIDTH($bits(entry_ctrl_t))) u_ent_ctrl (
        .clock (clock),
        .reset (reset),
        .wen   (accept),
        .din   ({in_rwen, in_ecall, in_mret}),
        .dout  (ent_c)
    );

    ysyx_22050550_mstatus_upd u_ms (
        .cur_mstatus  (cur_mstatus),
        .is_trap      (state == ST_TRAP2),
        .is_mret      (mret_act),
        .next_mstatus (ms_next)
    );

    // Sequencer: IDLE -> COMMIT (held while back-to-back) -> TRAP2 for ecall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state <= accept ? ST_COMMIT : ST_IDLE;
                ST_COMMIT: begin
                    if (ent_c.ecall) begin
                        state <= ST_TRAP2;
                    end else if (accept) begin
                        state <= ST_COMMIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_TRAP2:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Regfile-facing strobes and data for the current state
    always_comb begin
        io_waddr    = 5'd0;
        io_wdata    = '0;
        io_wen      = 1'b0;
        io_valid    = 1'b0;
        pc          = '0;
        wbcsren     = 8'd0;
        wbmepc      = '0;
        wbmcause    = '0;
        wbmtvec     = '0;
        wbmstatus   = '0;
        wbmie       = '0;
        wbmip       = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (state)
            ST_COMMIT: begin
                io_valid = 1'b1;
                pc       = ent_d.pc;
                if (ent_c.ecall) begin
                    wbcsren[CSR_MEPC]   = 1'b1;
                    wbcsren[CSR_MCAUSE] = 1'b1;
                    wbmepc              = ent_d.pc;
                    wbmcause            = ECALL_MC;
                end else begin
                    io_wen    = ent_c.rwen && (ent_d.rd != 5'd0);
                    io_waddr  = ent_d.rd;
                    io_wdata  = ent_d.rdata;
                    wbcsren   = {2'b00, ent_d.csrwen};
                    wbmepc    = ent_d.csrdata;
                    wbmcause  = ent_d.csrdata;
                    wbmtvec   = ent_d.csrdata;
                    wbmstatus = ent_d.csrdata;
                    wbmie     = ent_d.csrdata;
                    wbmip     = ent_d.csrdata;
                    if (ent_c.mret) begin
                        wbcsren[CSR_MSTATUS] = 1'b1;
                        wbmstatus            = ms_next;
                        redirect             = 1'b1;
                        redirect_pc          = cur_mepc;
                    end else begin
                        redirect = 1'b0;
                    end
                end
            end
            ST_TRAP2: begin
                wbcsren[CSR_MSTATUS] = 1'b1;
                wbmstatus            = ms_next;
                redirect             = 1'b1;
                redirect_pc          = trap_vector(cur_mtvec);
            end
            default: begin
                io_valid = 1'b0;
            end
        endcase
    end

`ifdef YSYX_22050550_WB_INSTRET_EN
    // Count every COMMIT cycle; TRAP2 is not a retirement
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret <= 64'd0;
        end else if (state == ST_COMMIT) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule
